// File: rtl/dtw_seq_pkg.sv
// Shared state encoding, field widths and address defaults for the DTW result sequencer.
package dtw_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int FIELD8_W        = 8;
  localparam int FIELD16_W       = 16;
  localparam int DEF_RESULT_BASE = 20;
  localparam int DEF_MAX_PATH    = 40;

endpackage

// File: rtl/dtw_wdata_pack.sv
// Combinational formatter for one result word: {ystatus, xstatus, result16}, zero-extended fields.
module dtw_wdata_pack
  import dtw_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DTW_W  = 12,
  parameter int STAT_W = 5,
  parameter int CNT_W  = 6
) (
  input  logic [CNT_W-1:0]  pt_counter,
  input  logic [STAT_W-1:0] xstatus,
  input  logic [STAT_W-1:0] ystatus,
  input  logic [DTW_W-1:0]  dtw_result,
  output logic [DATA_W-1:0] word
);

  logic [FIELD16_W-1:0]             result16;
  logic [2*FIELD8_W+FIELD16_W-1:0]  word32;

  // Only the first path step carries the DTW distance.
  always_comb begin
    result16 = (pt_counter == '0) ? FIELD16_W'(dtw_result) : '0;
    word32   = {FIELD8_W'(ystatus), FIELD8_W'(xstatus), result16};
  end

  assign word = DATA_W'(word32);

endmodule

// File: rtl/dtw_sram_sequencer.sv
// SRAM access sequencer for a DTW engine: loader reads during CALC, path results written in WRITE.
// Optional CALC watchdog enabled by defining DTW_SEQ_WATCHDOG_EN.
module dtw_sram_sequencer
  import dtw_seq_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int DTW_W       = 12,
  parameter int STAT_W      = 5,
  parameter int CNT_W       = 6,
  parameter int RESULT_BASE = DEF_RESULT_BASE,
  parameter int MAX_PATH    = DEF_MAX_PATH,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] sin_i,
  input  logic              mp_finish_i,
  input  logic              pt_ready_i,
  input  logic [CNT_W-1:0]  pt_counter_i,
  input  logic [STAT_W-1:0] xstatus_i,
  input  logic [STAT_W-1:0] ystatus_i,
  input  logic [ADDR_W-1:0] ld_idx_i,
  input  logic [DTW_W-1:0]  dtw_result_i,
  inout  tri logic [DATA_W-1:0] data_io,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] sin_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wr_o,
  output logic              cs_o,
  output logic              ready_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic              err_o
);

  state_t            state_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] wdata_next;
  logic [ADDR_W-1:0] wr_addr;
  logic              path_ovf;

  dtw_wdata_pack #(
    .DATA_W (DATA_W),
    .DTW_W  (DTW_W),
    .STAT_W (STAT_W),
    .CNT_W  (CNT_W)
  ) u_pack (
    .pt_counter (pt_counter_i),
    .xstatus    (xstatus_i),
    .ystatus    (ystatus_i),
    .dtw_result (dtw_result_i),
    .word       (wdata_next)
  );

  assign wr_addr  = ADDR_W'(RESULT_BASE) + ADDR_W'(pt_counter_i);
  assign path_ovf = 32'(pt_counter_i) >= 32'(MAX_PATH);

  // Data is registered alongside addr_o so both describe the same write cycle.
  assign data_io = (!cs_o && wr_o) ? wdata_reg : 'z;
  assign rdata_o = data_io;

`ifdef DTW_SEQ_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0] wd_cnt_reg;
  logic            err_reg;
  assign err_o = err_reg;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg  <= S_IDLE;
      ready_o    <= 1'b1;
      cs_o       <= 1'b1;
      wr_o       <= 1'b0;
      done_o     <= 1'b0;
      ovf_o      <= 1'b0;
      addr_o     <= '0;
      sin_o      <= '0;
      wdata_reg  <= '0;
`ifdef DTW_SEQ_WATCHDOG_EN
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
`endif
    end else begin
      sin_o  <= sin_i;
      done_o <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (valid_i) begin
            state_reg  <= S_CALC;
            ready_o    <= 1'b0;
            cs_o       <= 1'b0;
            wr_o       <= 1'b0;
            addr_o     <= ld_idx_i;
            ovf_o      <= 1'b0;
`ifdef DTW_SEQ_WATCHDOG_EN
            wd_cnt_reg <= '0;
            err_reg    <= 1'b0;
`endif
          end
        end
        S_CALC: begin
          addr_o <= ld_idx_i;
          if (mp_finish_i) begin
            state_reg <= S_WRITE;
            wr_o      <= 1'b1;
            addr_o    <= wr_addr;
            wdata_reg <= wdata_next;
            cs_o      <= path_ovf;
            if (path_ovf) ovf_o <= 1'b1;
          end
`ifdef DTW_SEQ_WATCHDOG_EN
          else if (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1)) begin
            state_reg <= S_IDLE;
            ready_o   <= 1'b1;
            cs_o      <= 1'b1;
            err_reg   <= 1'b1;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
          end
`endif
        end
        S_WRITE: begin
          if (pt_ready_i) begin
            state_reg <= S_DONE;
            done_o    <= 1'b1;
            cs_o      <= 1'b1;
            wr_o      <= 1'b0;
          end else begin
            // Out-of-range path slots are skipped by deselecting the SRAM.
            addr_o    <= wr_addr;
            wdata_reg <= wdata_next;
            cs_o      <= path_ovf;
            if (path_ovf) ovf_o <= 1'b1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          ready_o   <= 1'b1;
        end
        default: begin
          state_reg <= S_IDLE;
          ready_o   <= 1'b1;
          cs_o      <= 1'b1;
          wr_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule
